// File: rtl/cpa_pkg.sv
// Shared definitions for the sequential multi-word carry-propagate adder.
// Contents:
//   cpa_seq_state_e - controller states (idle, running slices, result held)
//   idx_width()     - width of the slice index counter for a given word count
package cpa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } cpa_seq_state_e;

  // A single-word adder still needs a 1-bit index so the counter is never
  // zero-width.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/rca_nbits.sv
// N-bit ripple-carry adder, purely combinational.
// Ports:
//   a, b  in  BITS  addends
//   ci    in  1     carry-in to bit 0
//   s     out BITS  sum
//   co    out 1     carry-out of the top bit
module rca_nbits #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  output logic [BITS-1:0] s,
  output logic            co
);

  // The carry is walked through a single variable so the chain is one
  // evaluation rather than a feedback loop through a vector.
  always_comb begin
    logic carry;
    carry = ci;
    s     = '0;
    for (int i = 0; i < BITS; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/cpa_seq_multiword.sv
// Sequential multi-word carry-propagate adder. Adds two WORDS*BITS-bit
// operands one BITS-bit slice per cycle (least-significant first) through a
// single rca_nbits, holding the inter-slice carry in a register.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, ci)
//   a, b                 W-bit operands, ci carry-in to slice 0
//   out_valid / out_ready result handshake
//   s                    W-bit sum (modulo 2^W)
//   co                   carry-out of the top slice
//   ovf                  two's-complement signed overflow of the W-bit add
module cpa_seq_multiword
  import cpa_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*BITS-1:0] a,
  input  logic [WORDS*BITS-1:0] b,
  input  logic                  ci,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*BITS-1:0] s,
  output logic                  co,
  output logic                  ovf
);

  localparam int W  = WORDS * BITS;
  localparam int IW = idx_width(WORDS);

  cpa_seq_state_e  state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IW-1:0]   idx;

  logic [BITS-1:0] a_slice;
  logic [BITS-1:0] b_slice;
  logic [BITS-1:0] sum_slice;
  logic            add_co;
  logic            last_slice;
  logic            run;

  assign a_slice    = a_q[int'(idx) * BITS +: BITS];
  assign b_slice    = b_q[int'(idx) * BITS +: BITS];
  assign last_slice = (idx == IW'(WORDS - 1));
  assign run        = (state == S_RUN);

  rca_nbits #(.BITS(BITS)) u_rca (
    .a  (a_slice),
    .b  (b_slice),
    .ci (carry_q),
    .s  (sum_slice),
    .co (add_co)
  );

  // Handshake outputs decode the state directly; reset masks in_ready so a
  // request coinciding with reset is never seen as accepted.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            idx     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q <= add_co;
          if (last_slice) begin
            // The top slice's sum MSB is bit W-1 of the full result.
            state <= S_DONE;
            co    <= add_co;
            ovf   <= (a_q[W-1] == b_q[W-1]) && (sum_slice[BITS-1] != a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One register per result word; each loads only on the cycle its slice is
  // on the adder, so the sum stays frozen through DONE and backpressure.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [BITS-1:0] word_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          word_q <= '0;
        end else if (run && (idx == IW'(gi))) begin
          word_q <= sum_slice;
        end
      end

      assign s[gi*BITS +: BITS] = word_q;
    end
  endgenerate

endmodule

// File: tb/tb_cpa_seq_multiword.sv
// Self-checking bench for cpa_seq_multiword: a BITS=8/WORDS=4 instance and a
// BITS=8/WORDS=1 instance share clock and reset. Expected results come from a
// plain integer-add model, queued at issue and popped when out_valid rises.
module tb_cpa_seq_multiword;

  localparam int BITS = 8;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, ci4, co4, ovf4;
  logic [31:0] a4, b4, s4;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, ci1, co1, ovf1;
  logic [7:0]  a1, b1, s1;

  exp_t q4[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cpa_seq_multiword #(.BITS(BITS), .WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .ci(ci4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .co(co4), .ovf(ovf4)
  );

  cpa_seq_multiword #(.BITS(BITS), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .co(co1), .ovf(ovf1)
  );

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] full;
    exp_t e;
    full  = {1'b0, x} + {1'b0, y} + 33'(c);
    e.s   = full[31:0];
    e.co  = full[32];
    e.ovf = (x[31] == y[31]) && (full[31] != x[31]);
    return e;
  endfunction

  function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    exp_t e;
    full  = {1'b0, x} + {1'b0, y} + 9'(c);
    e.s   = {24'd0, full[7:0]};
    e.co  = full[8];
    e.ovf = (x[7] == y[7]) && (full[7] != x[7]);
    return e;
  endfunction

  // Issue one add on the 4-word instance, check latency and result, optionally
  // hold the result under backpressure while presenting the next operands.
  task automatic do_op4(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                        input int hold, input logic [31:0] na, input logic [31:0] nb,
                        input logic nci);
    exp_t e;
    int   lat;
    a4 = ta; b4 = tb; ci4 = tci; in_valid4 = 1'b1;
    q4.push_back(model32(ta, tb, tci));
    check("in_ready_at_issue4", 64'(in_ready4), 64'd1);
    tick();
    in_valid4 = 1'b0;
    check("in_ready_busy4", 64'(in_ready4), 64'd0);
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency4", 64'(lat), 64'd4);
    checks++;
    assert (q4.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard4 observed=empty expected=entry");
    end
    if (q4.size() != 0) begin
      e = q4.pop_front();
      check("sum4", 64'(s4), 64'(e.s));
      check("co4", 64'(co4), 64'(e.co));
      check("ovf4", 64'(ovf4), 64'(e.ovf));
      $display("txn w4 a=%08h b=%08h ci=%0d -> s=%08h co=%0d ovf=%0d", ta, tb, tci, s4, co4, ovf4);
      if (hold > 0) begin
        a4 = na; b4 = nb; ci4 = nci; in_valid4 = 1'b1;
        for (int i = 0; i < hold; i++) begin
          tick();
          check("hold_out_valid4", 64'(out_valid4), 64'd1);
          check("hold_in_ready4", 64'(in_ready4), 64'd0);
          check("hold_sum4", 64'(s4), 64'(e.s));
          check("hold_co4", 64'(co4), 64'(e.co));
          check("hold_ovf4", 64'(ovf4), 64'(e.ovf));
        end
      end
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    in_valid4  = 1'b0;
    check("post_hs_out_valid4", 64'(out_valid4), 64'd0);
    check("post_hs_in_ready4", 64'(in_ready4), 64'd1);
  endtask

  task automatic do_op1(input logic [7:0] ta, input logic [7:0] tb, input logic tci);
    exp_t e;
    int   lat;
    a1 = ta; b1 = tb; ci1 = tci; in_valid1 = 1'b1;
    q1.push_back(model8(ta, tb, tci));
    check("in_ready_at_issue1", 64'(in_ready1), 64'd1);
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency1", 64'(lat), 64'd1);
    checks++;
    assert (q1.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard1 observed=empty expected=entry");
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      check("sum1", 64'(s1), 64'(e.s[7:0]));
      check("co1", 64'(co1), 64'(e.co));
      check("ovf1", 64'(ovf1), 64'(e.ovf));
      $display("txn w1 a=%02h b=%02h ci=%0d -> s=%02h co=%0d ovf=%0d", ta, tb, tci, s1, co1, ovf1);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("post_hs_in_ready1", 64'(in_ready1), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;

    // Reset state, with an in_valid that must not be taken during reset.
    in_valid4 = 1'b1;
    tick();
    tick();
    check("rst_in_ready4", 64'(in_ready4), 64'd0);
    check("rst_out_valid4", 64'(out_valid4), 64'd0);
    check("rst_sum4", 64'(s4), 64'd0);
    check("rst_co4", 64'(co4), 64'd0);
    check("rst_ovf4", 64'(ovf4), 64'd0);
    check("rst_in_ready1", 64'(in_ready1), 64'd0);
    in_valid4 = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_in_ready4", 64'(in_ready4), 64'd1);
    check("idle_out_valid4", 64'(out_valid4), 64'd0);

    // Directed adds on the 4-word instance.
    do_op4(32'h000000FF, 32'h00000001, 1'b0, 0, '0, '0, 1'b0);
    do_op4(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, '0, '0, 1'b0);
    do_op4(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, '0, '0, 1'b0);

    // Backpressure for 5 cycles with the next request already presented.
    do_op4(32'h80000000, 32'h80000000, 1'b0, 5, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
    do_op4(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 0, '0, '0, 1'b0);

    // Abort: reset while the third slice (idx=2) is on the adder.
    a4 = 32'hAAAAAAAA; b4 = 32'h55555555; ci4 = 1'b1; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_out_valid4", 64'(out_valid4), 64'd0);
    check("abort_in_ready4", 64'(in_ready4), 64'd1);
    check("abort_sum4", 64'(s4), 64'd0);
    check("abort_co4", 64'(co4), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid4", 64'(out_valid4), 64'd0);
    end
    do_op4(32'h12345678, 32'h11111111, 1'b0, 0, '0, '0, 1'b0);

    // Single-word instance.
    do_op1(8'h80, 8'h80, 1'b0);
    do_op1(8'h7F, 8'h01, 1'b0);

    check("q4_drained", 64'(q4.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
